// File: rtl/exc_pkg.sv
// Shared types and encodings for the LEGv8 exception/return controller.
package exc_pkg;

  typedef enum logic [1:0] {
    StRun,
    StTake,
    StHandler,
    StRet
  } exc_state_e;

  localparam logic [1:0] EsrNone        = 2'd0;
  localparam logic [1:0] EsrInvalid     = 2'd1;
  localparam logic [1:0] EsrIrq         = 2'd2;
  localparam logic [1:0] EsrIllegalEret = 2'd3;

  localparam logic [1:0] MrsElr   = 2'b00;
  localparam logic [1:0] MrsEsr   = 2'b01;
  localparam logic [1:0] MrsCount = 2'b10;

endpackage

// File: rtl/sat_counter.sv
// W-bit up counter that sticks at all-ones; synchronous clear has priority.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (clr) begin
      r_count <= '0;
    end else if (inc && (r_count != {W{1'b1}})) begin
      r_count <= r_count + W'(1);
    end
  end

  assign count = r_count;

endmodule

// File: rtl/exception_ctrl.sv
// Exception entry/return sequencer: captures ELR/ESR, pulses pipeline redirects,
// and serves ELR/ESR/exception count to the MRS read path.
module exception_ctrl #(
  parameter int unsigned   N          = 64,
  parameter logic [N-1:0]  EXC_VECTOR = 64'h0000_0000_0000_00D8,
  parameter int unsigned   CW         = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         InstrValid,
  input  logic         NotAnInstr,
  input  logic         ERet,
  input  logic [N-1:0] PC_E,
  input  logic         ExtIRQ,
  output logic         ExtIAck,
  output logic         Exc,
  output logic         ERetOut,
  output logic [N-1:0] RedirectPC,
  output logic         ExcActive,
  output logic         Fault,
  input  logic [1:0]   MrsSel,
  output logic [N-1:0] MrsData
);
  import exc_pkg::*;

  exc_state_e    r_state;
  logic [N-1:0]  r_elr;
  logic [1:0]    r_esr;
  logic          r_fault;
  logic          r_exc;
  logic          r_eret;
  logic          r_iack;
  logic          r_active;
  logic          w_take;
  logic [1:0]    w_code;
  logic [CW-1:0] w_count;

  // Cause priority in RUN: invalid opcode, then stray ERET, then interrupt.
  always_comb begin
    w_take = 1'b1;
    w_code = EsrNone;
    if (InstrValid && NotAnInstr) begin
      w_code = EsrInvalid;
    end else if (InstrValid && ERet) begin
      w_code = EsrIllegalEret;
    end else if (ExtIRQ) begin
      w_code = EsrIrq;
    end else begin
      w_take = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= StRun;
      r_elr    <= '0;
      r_esr    <= EsrNone;
      r_fault  <= 1'b0;
      r_exc    <= 1'b0;
      r_eret   <= 1'b0;
      r_iack   <= 1'b0;
      r_active <= 1'b0;
    end else begin
      r_exc  <= 1'b0;
      r_eret <= 1'b0;
      r_iack <= 1'b0;
      unique case (r_state)
        StRun: begin
          r_active <= 1'b0;
          if (w_take) begin
            r_state <= StTake;
            r_elr   <= PC_E;
            r_esr   <= w_code;
            r_exc   <= 1'b1;
            r_iack  <= (w_code == EsrIrq);
          end
        end
        StTake: begin
          r_state  <= StHandler;
          r_active <= 1'b1;
        end
        StHandler: begin
          if (InstrValid && ERet) begin
            r_state <= StRet;
            r_eret  <= 1'b1;
          end else if (InstrValid && NotAnInstr) begin
            r_fault <= 1'b1;
          end
        end
        StRet: begin
          r_state  <= StRun;
          r_active <= 1'b0;
        end
        default: r_state <= StRun;
      endcase
    end
  end

  sat_counter #(
    .W(CW)
  ) u_sat_counter (
    .clk  (clk),
    .clr  (reset),
    .inc  ((r_state == StRun) && w_take),
    .count(w_count)
  );

  always_comb begin
    case (MrsSel)
      MrsElr:   MrsData = r_elr;
      MrsEsr:   MrsData = {{(N-2){1'b0}}, r_esr};
      MrsCount: MrsData = {{(N-CW){1'b0}}, w_count};
      default:  MrsData = '0;
    endcase
  end

  assign RedirectPC = r_exc ? EXC_VECTOR : (r_eret ? r_elr : '0);
  assign Exc        = r_exc;
  assign ERetOut    = r_eret;
  assign ExtIAck    = r_iack;
  assign ExcActive  = r_active;
  assign Fault      = r_fault;

endmodule

// File: tb/tb_exception_ctrl.sv
// Directed bench for exception_ctrl: outcome model checked every cycle plus literal pins.
module tb_exception_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        InstrValid = 1'b0;
  logic        NotAnInstr = 1'b0;
  logic        ERet = 1'b0;
  logic [63:0] PC_E = '0;
  logic        ExtIRQ = 1'b0;
  logic [1:0]  MrsSel = 2'b00;

  logic        ExtIAck, Exc, ERetOut, ExcActive, Fault;
  logic [63:0] RedirectPC, MrsData;
  logic        s_ExtIAck, s_Exc, s_ERetOut, s_ExcActive, s_Fault;
  logic [63:0] s_RedirectPC, s_MrsData;

  int n_tests = 0;
  int n_fail  = 0;

  always #10 clk = ~clk;

  exception_ctrl u_dut (
    .clk(clk), .reset(reset), .InstrValid(InstrValid), .NotAnInstr(NotAnInstr), .ERet(ERet),
    .PC_E(PC_E), .ExtIRQ(ExtIRQ), .ExtIAck(ExtIAck), .Exc(Exc), .ERetOut(ERetOut),
    .RedirectPC(RedirectPC), .ExcActive(ExcActive), .Fault(Fault), .MrsSel(MrsSel),
    .MrsData(MrsData)
  );

  // Narrow-counter copy so saturation is reachable in a short run.
  exception_ctrl #(.CW(4)) u_dut_sat (
    .clk(clk), .reset(reset), .InstrValid(InstrValid), .NotAnInstr(NotAnInstr), .ERet(ERet),
    .PC_E(PC_E), .ExtIRQ(ExtIRQ), .ExtIAck(s_ExtIAck), .Exc(s_Exc), .ERetOut(s_ERetOut),
    .RedirectPC(s_RedirectPC), .ExcActive(s_ExcActive), .Fault(s_Fault), .MrsSel(MrsSel),
    .MrsData(s_MrsData)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: what each output must be in the cycle following every edge.
  bit          m_live = 1'b0;
  bit          m_exc, m_ret, m_iack, m_active, m_fault;
  logic [63:0] m_elr;
  int          m_esr, m_cnt;

  initial begin
    m_exc = 0; m_ret = 0; m_iack = 0; m_active = 0; m_fault = 0;
    m_elr = '0; m_esr = 0; m_cnt = 0;
  end

  always @(posedge clk) begin
    int cause;
    m_live = 1'b1;
    if (reset) begin
      m_exc = 0; m_ret = 0; m_iack = 0; m_active = 0; m_fault = 0;
      m_elr = '0; m_esr = 0; m_cnt = 0;
    end else if (m_exc) begin
      m_exc = 0; m_iack = 0; m_active = 1;
    end else if (m_ret) begin
      m_ret = 0; m_active = 0;
    end else if (m_active) begin
      if (InstrValid && ERet) m_ret = 1;
      else if (InstrValid && NotAnInstr) m_fault = 1;
    end else begin
      cause = (InstrValid && NotAnInstr) ? 1 : (InstrValid && ERet) ? 3 : ExtIRQ ? 2 : 0;
      if (cause != 0) begin
        m_elr = PC_E; m_esr = cause; m_cnt++; m_exc = 1; m_iack = (cause == 2);
      end
    end
  end

  function automatic logic [63:0] exp_mrs(input int cap);
    case (MrsSel)
      2'b00:   return m_elr;
      2'b01:   return 64'(m_esr);
      2'b10:   return 64'((m_cnt > cap) ? cap : m_cnt);
      default: return 64'd0;
    endcase
  endfunction

  always @(negedge clk) begin
    if (m_live) begin
      chk("Exc", {63'd0, Exc}, {63'd0, m_exc});
      chk("ERetOut", {63'd0, ERetOut}, {63'd0, m_ret});
      chk("ExtIAck", {63'd0, ExtIAck}, {63'd0, m_iack});
      chk("ExcActive", {63'd0, ExcActive}, {63'd0, m_active});
      chk("Fault", {63'd0, Fault}, {63'd0, m_fault});
      chk("RedirectPC", RedirectPC, m_exc ? 64'hD8 : (m_ret ? m_elr : 64'd0));
      chk("MrsData", MrsData, exp_mrs(65535));
      chk("sat.Exc", {63'd0, s_Exc}, {63'd0, m_exc});
      chk("sat.MrsData", s_MrsData, exp_mrs(15));
    end
  end

  // Apply one cycle of inputs; returns 2 time units after the sampling edge.
  task automatic drive(input logic rst, input logic iv, input logic nai, input logic er,
                       input logic [63:0] pc, input logic irq);
    reset = rst; InstrValid = iv; NotAnInstr = nai; ERet = er; PC_E = pc; ExtIRQ = irq;
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input logic irq);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 64'h0, irq);
  endtask

  task automatic mrs_chk(input string name, input logic [63:0] elr, input logic [63:0] esr,
                         input logic [63:0] cnt);
    MrsSel = 2'b00; #1; chk({name, ".elr"}, MrsData, elr);
    MrsSel = 2'b01; #1; chk({name, ".esr"}, MrsData, esr);
    MrsSel = 2'b10; #1; chk({name, ".cnt"}, MrsData, cnt);
    MrsSel = 2'b11; #1; chk({name, ".zero"}, MrsData, 64'd0);
    MrsSel = 2'b00;
  endtask

  task automatic all_zero(input string name);
    chk({name, ".out"}, {59'd0, Exc, ERetOut, ExtIAck, ExcActive, Fault}, 64'd0);
    chk({name, ".redir"}, RedirectPC, 64'd0);
    mrs_chk(name, 64'd0, 64'd0, 64'd0);
  endtask

  initial begin
    drive(1'b1, 1'b0, 1'b0, 1'b0, 64'h0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 64'h0, 1'b0);
    all_zero("reset");
    idle(1'b0);

    // Invalid opcode, then ERET from the handler.
    drive(1'b0, 1'b1, 1'b1, 1'b0, 64'h40, 1'b0);
    chk("inv.Exc", {63'd0, Exc}, 64'd1);
    chk("inv.redir", RedirectPC, 64'hD8);
    chk("inv.ack", {63'd0, ExtIAck}, 64'd0);
    mrs_chk("inv", 64'h40, 64'd1, 64'd1);
    idle(1'b0);
    chk("inv.active", {62'd0, ExcActive, Exc}, 64'd2);
    drive(1'b0, 1'b1, 1'b0, 1'b1, 64'h44, 1'b0);
    chk("ret.pulse", {62'd0, ERetOut, ExcActive}, 64'd3);
    chk("ret.redir", RedirectPC, 64'h40);
    idle(1'b0);
    chk("ret.done", {62'd0, ERetOut, ExcActive}, 64'd0);

    // IRQ held; re-raised inside the handler is ignored until after return.
    drive(1'b0, 1'b0, 1'b0, 1'b0, 64'h100, 1'b1);
    chk("irq.ack", {62'd0, ExtIAck, Exc}, 64'd3);
    mrs_chk("irq", 64'h100, 64'd2, 64'd2);
    idle(1'b0);
    idle(1'b1);
    idle(1'b1);
    chk("irq.masked", {62'd0, Exc, ExtIAck}, 64'd0);
    drive(1'b0, 1'b1, 1'b0, 1'b1, 64'h104, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 64'h200, 1'b1);
    chk("irq.runslot", {63'd0, Exc}, 64'd0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 64'h200, 1'b1);
    chk("irq.retake", {62'd0, ExtIAck, Exc}, 64'd3);
    mrs_chk("irq2", 64'h200, 64'd2, 64'd3);
    idle(1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b1, 64'h204, 1'b0);
    idle(1'b0);

    // Invalid opcode beats a simultaneous IRQ; IRQ taken after return.
    drive(1'b0, 1'b1, 1'b1, 1'b0, 64'h300, 1'b1);
    chk("both.ack", {62'd0, ExtIAck, Exc}, 64'd1);
    mrs_chk("both", 64'h300, 64'd1, 64'd4);
    idle(1'b1);
    drive(1'b0, 1'b1, 1'b0, 1'b1, 64'h304, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 64'h308, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 64'h308, 1'b1);
    chk("both.irq", {62'd0, ExtIAck, Exc}, 64'd3);
    idle(1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b1, 64'h30C, 1'b0);
    idle(1'b0);

    // Double fault is sticky and leaves ELR/ESR alone.
    drive(1'b0, 1'b1, 1'b1, 1'b0, 64'h500, 1'b0);
    idle(1'b0);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 64'h600, 1'b0);
    chk("fault.set", {62'd0, Fault, Exc}, 64'd2);
    mrs_chk("fault", 64'h500, 64'd1, 64'd6);
    drive(1'b0, 1'b1, 1'b0, 1'b1, 64'h604, 1'b0);
    chk("fault.ret", RedirectPC, 64'h500);
    idle(1'b0);

    // Stray ERET in RUN, then ERET+invalid together in the handler.
    drive(1'b0, 1'b1, 1'b0, 1'b1, 64'h700, 1'b0);
    chk("ill.Exc", {63'd0, Exc}, 64'd1);
    mrs_chk("ill", 64'h700, 64'd3, 64'd7);
    idle(1'b0);
    drive(1'b0, 1'b1, 1'b1, 1'b1, 64'h704, 1'b0);
    chk("eretwins", {62'd0, ERetOut, Fault}, 64'd3);
    chk("eretwins.redir", RedirectPC, 64'h700);
    idle(1'b0);
    drive(1'b0, 1'b0, 1'b1, 1'b1, 64'h708, 1'b0);
    chk("novalid", {62'd0, Exc, Fault}, 64'd1);

    // Reset during TAKE, then during RET.
    drive(1'b0, 1'b1, 1'b1, 1'b0, 64'h800, 1'b0);
    chk("rtake.pre", {63'd0, Exc}, 64'd1);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 64'h0, 1'b0);
    all_zero("rtake");
    idle(1'b0);
    chk("rtake.run", {62'd0, Exc, ExcActive}, 64'd0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 64'h900, 1'b1);
    idle(1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b1, 64'h904, 1'b0);
    chk("rret.pre", {63'd0, ERetOut}, 64'd1);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 64'h0, 1'b0);
    all_zero("rret");

    // Twenty exceptions: wide counter reads 20, narrow one sticks at 15.
    for (int i = 0; i < 20; i++) begin
      drive(1'b0, 1'b1, 1'b1, 1'b0, 64'(32'h1000 + 4 * i), 1'b0);
      idle(1'b0);
      drive(1'b0, 1'b1, 1'b0, 1'b1, 64'h0, 1'b0);
      idle(1'b0);
    end
    MrsSel = 2'b10; #1;
    chk("sat.wide", MrsData, 64'd20);
    chk("sat.narrow", s_MrsData, 64'hF);
    MrsSel = 2'b00;
    idle(1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
